// File: rtl/comb_sweep_ctrl_if.sv
// Signal bundle between the sweep sequencer and whoever starts it / observes it.
// The function-block drive (abcd_out) and its response (y_in) travel in the same bundle.
interface comb_sweep_ctrl_if;
    logic        start;
    logic        hold;
    logic [15:0] expected;
    logic        y_in;
    logic [3:0]  abcd_out;
    logic        busy;
    logic        done;
    logic [15:0] truth_table;
    logic [4:0]  mismatch_cnt;
    logic        pass;

    modport master (
        output start, hold, expected, y_in,
        input  abcd_out, busy, done, truth_table, mismatch_cnt, pass
    );

    modport slave (
        input  start, hold, expected, y_in,
        output abcd_out, busy, done, truth_table, mismatch_cnt, pass
    );
endinterface

// File: rtl/comb_sweep_ctrl.sv
// Exhaustive truth-table sweep of a 4-input combinational block against a golden table.
// Define COMB_SWEEP_GRAY_EN to step the inputs in Gray order instead of binary order.
module comb_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic              clk,
    input logic              rst_n,
    comb_sweep_ctrl_if.slave ctrl_io
);

    localparam logic [3:0] SettleReload = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  settle_q, settle_d;
    logic [15:0] exp_q, exp_d;
    logic [3:0]  abcd_q, abcd_d;
    logic [15:0] tt_q, tt_d;
    logic [4:0]  mm_q, mm_d;
    logic        pass_q, pass_d;

    // Step index to applied vector; results are always indexed by the vector value.
    function automatic logic [3:0] vec(input logic [3:0] i);
`ifdef COMB_SWEEP_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= 4'd0;
            settle_q <= 4'd0;
            exp_q    <= 16'd0;
            abcd_q   <= 4'd0;
            tt_q     <= 16'd0;
            mm_q     <= 5'd0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            exp_q    <= exp_d;
            abcd_q   <= abcd_d;
            tt_q     <= tt_d;
            mm_q     <= mm_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        exp_d    = exp_q;
        abcd_d   = abcd_q;
        tt_d     = tt_q;
        mm_d     = mm_q;
        pass_d   = pass_q;

        unique case (state_q)
            StIdle: begin
                if (ctrl_io.start) begin
                    exp_d    = ctrl_io.expected;
                    tt_d     = 16'd0;
                    mm_d     = 5'd0;
                    pass_d   = 1'b0;
                    idx_d    = 4'd0;
                    abcd_d   = vec(4'd0);
                    settle_d = SettleReload;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (!ctrl_io.hold) begin
                    if (settle_q == 4'd0) begin
                        state_d = StSample;
                    end else begin
                        settle_d = settle_q - 4'd1;
                    end
                end
            end
            StSample: begin
                if (!ctrl_io.hold) begin
                    tt_d[abcd_q] = ctrl_io.y_in;
                    if (ctrl_io.y_in != exp_q[abcd_q]) begin
                        mm_d = mm_q + 5'd1;
                    end
                    if (idx_q == 4'd15) begin
                        state_d = StDone;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        abcd_d   = vec(idx_q + 4'd1);
                        settle_d = SettleReload;
                        state_d  = StSettle;
                    end
                end
            end
            StDone: begin
                // mm_q already includes the final sample taken on the edge into this state.
                pass_d  = (mm_q == 5'd0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign ctrl_io.abcd_out     = abcd_q;
    assign ctrl_io.busy         = (state_q != StIdle);
    assign ctrl_io.done         = (state_q == StDone);
    assign ctrl_io.truth_table  = tt_q;
    assign ctrl_io.mismatch_cnt = mm_q;
    assign ctrl_io.pass         = pass_q;

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Scoreboard bench for comb_sweep_ctrl: stimulus pushes expected sweep results, a monitor
// checks them when done pulses. Honours COMB_SWEEP_GRAY_EN for the expected vector order.
module tb_comb_sweep_ctrl;

    localparam int S = 2;

    typedef struct packed {
        logic [15:0] tt;
        logic [4:0]  mm;
        logic        pass;
        logic [7:0]  done_cyc;
        logic        chk_dur;
    } exp_t;

    logic clk;
    logic rst_n;
    comb_sweep_ctrl_if sweep_if ();

    comb_sweep_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl_io (sweep_if)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          fn_mode  = 0;
    logic [15:0] fn_tab   = 16'd0;
    exp_t        sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural function block under test.
    always_comb begin
        case (fn_mode)
            0:       sweep_if.y_in = (sweep_if.abcd_out[3] & sweep_if.abcd_out[2]) |
                                     (sweep_if.abcd_out[1] & sweep_if.abcd_out[0]);
            1:       sweep_if.y_in = 1'b1;
            default: sweep_if.y_in = fn_tab[sweep_if.abcd_out];
        endcase
    end

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [3:0] vec_of(input int k);
        logic [3:0] b;
        b = 4'(k);
`ifdef COMB_SWEEP_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    // ---------------- monitor ----------------
    int         run_len = 0;
    logic       prev_busy = 1'b0;
    logic       pend_pass = 1'b0;
    logic       pend_val = 1'b0;
    logic [3:0] seq_q[$];
    int         dur_q[$];
    exp_t       e;
    int         verr, derr, herr;

    always @(negedge clk) begin
        if (!rst_n) begin
            run_len   = 0;
            pend_pass = 1'b0;
            prev_busy = 1'b0;
            seq_q.delete();
            dur_q.delete();
        end else begin
            if (pend_pass) begin
                check("pass", 32'(sweep_if.pass), 32'(pend_val));
                check("busy_after_done", 32'(sweep_if.busy), 32'd0);
                pend_pass = 1'b0;
            end
            if (sweep_if.busy && !prev_busy) begin
                seq_q.delete();
                dur_q.delete();
                run_len = 0;
            end
            if (sweep_if.busy) run_len++;
            else run_len = 0;
            if (sweep_if.busy && !sweep_if.done) begin
                if (seq_q.size() == 0 || sweep_if.abcd_out != seq_q[$]) begin
                    seq_q.push_back(sweep_if.abcd_out);
                    dur_q.push_back(1);
                end else begin
                    dur_q[$] = dur_q[$] + 1;
                end
            end
            if (sweep_if.done) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, required no done at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("done_cycle", 32'(run_len), 32'(e.done_cyc));
                    check("truth_table", 32'(sweep_if.truth_table), 32'(e.tt));
                    check("mismatch_cnt", 32'(sweep_if.mismatch_cnt), 32'(e.mm));
                    check("vector_count", 32'(seq_q.size()), 32'd16);
                    verr = 0;
                    derr = 0;
                    herr = 0;
                    for (int k = 0; k < seq_q.size() && k < 16; k++) begin
                        if (seq_q[k] != vec_of(k)) verr++;
                        if (e.chk_dur && dur_q[k] != S + 1) derr++;
                        if (k > 0 && $countones(seq_q[k] ^ seq_q[k-1]) != 1) herr++;
                    end
                    check("vector_order_errs", 32'(verr), 32'd0);
                    if (e.chk_dur) check("vector_hold_errs", 32'(derr), 32'd0);
`ifdef COMB_SWEEP_GRAY_EN
                    check("gray_step_errs", 32'(herr), 32'd0);
`endif
                    pend_pass = 1'b1;
                    pend_val  = e.pass;
                end
            end
            prev_busy = sweep_if.busy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_exp(input logic [15:0] tt, input logic [4:0] mm, input logic p,
                            input int cyc, input logic dur);
        exp_t x;
        x.tt       = tt;
        x.mm       = mm;
        x.pass     = p;
        x.done_cyc = 8'(cyc);
        x.chk_dur  = dur;
        sb_q.push_back(x);
    endtask

    // Returns at the negedge of cycle 1 (first cycle after the accepting edge).
    task automatic start_sweep(input logic [15:0] exp);
        @(negedge clk);
        sweep_if.expected = exp;
        sweep_if.start    = 1'b1;
        @(negedge clk);
        sweep_if.start    = 1'b0;
    endtask

    task automatic finish_sweep(input logic [15:0] tt_exp);
        int cnt;
        cnt = 0;
        while ((sb_q.size() != 0 || sweep_if.busy || pend_pass) && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL sweep_timeout: got no completion, required done within 400 cycles");
            sb_q.delete();
        end
        repeat (3) @(negedge clk);
        check("tt_held_idle", 32'(sweep_if.truth_table), 32'(tt_exp));
        check("abcd_final_idle", 32'(sweep_if.abcd_out), 32'(vec_of(15)));
    endtask

    initial begin
        logic [15:0] rexp;
        logic [4:0]  rmm;
        int          cnt;

        rst_n             = 1'b0;
        sweep_if.start    = 1'b0;
        sweep_if.hold     = 1'b0;
        sweep_if.expected = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_abcd", 32'(sweep_if.abcd_out), 32'd0);
        check("rst_busy", 32'(sweep_if.busy), 32'd0);
        check("rst_done", 32'(sweep_if.done), 32'd0);
        check("rst_tt", 32'(sweep_if.truth_table), 32'd0);
        check("rst_mm", 32'(sweep_if.mismatch_cnt), 32'd0);
        check("rst_pass", 32'(sweep_if.pass), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Correct function, (A&B)|(C&D).
        fn_mode = 0;
        push_exp(16'hF888, 5'd0, 1'b1, 49, 1'b1);
        start_sweep(16'hF888);
        finish_sweep(16'hF888);

        // Reset 20 cycles into a sweep: no done, outputs cleared, then a clean sweep.
        start_sweep(16'hF888);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_abcd", 32'(sweep_if.abcd_out), 32'd0);
        check("abort_busy", 32'(sweep_if.busy), 32'd0);
        check("abort_done", 32'(sweep_if.done), 32'd0);
        check("abort_tt", 32'(sweep_if.truth_table), 32'd0);
        check("abort_mm", 32'(sweep_if.mismatch_cnt), 32'd0);
        check("abort_pass", 32'(sweep_if.pass), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_exp(16'hF888, 5'd0, 1'b1, 49, 1'b1);
        start_sweep(16'hF888);
        finish_sweep(16'hF888);

        // Stuck-at-1 output.
        fn_mode = 1;
        push_exp(16'hFFFF, 5'd9, 1'b0, 49, 1'b1);
        start_sweep(16'hF888);
        finish_sweep(16'hFFFF);

        // Hold for 10 cycles in vector 5, start while busy and in the done cycle.
        fn_mode = 0;
        push_exp(16'hF888, 5'd0, 1'b1, 59, 1'b0);
        start_sweep(16'hF888);
        repeat (4) @(negedge clk);
        sweep_if.start = 1'b1;
        @(negedge clk);
        sweep_if.start = 1'b0;
        repeat (10) @(negedge clk);
        sweep_if.hold = 1'b1;
        repeat (10) @(negedge clk);
        sweep_if.hold = 1'b0;
        cnt = 0;
        while (!sweep_if.done && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        sweep_if.start = 1'b1;
        @(negedge clk);
        sweep_if.start = 1'b0;
        finish_sweep(16'hF888);
        check("start_in_done_ignored", 32'(sweep_if.busy), 32'd0);

        // Expected table changed mid-sweep has no effect.
        push_exp(16'hF888, 5'd0, 1'b1, 49, 1'b1);
        start_sweep(16'hF888);
        repeat (9) @(negedge clk);
        sweep_if.expected = 16'h0000;
        finish_sweep(16'hF888);

        // Random functions against random or matching golden tables.
        fn_mode = 2;
        for (int n = 0; n < 8; n++) begin
            fn_tab = 16'($urandom);
            rexp   = ($urandom_range(0, 1) == 1) ? fn_tab : 16'($urandom);
            rmm    = 5'($countones(fn_tab ^ rexp));
            push_exp(fn_tab, rmm, (rmm == 5'd0), 49, 1'b1);
            start_sweep(rexp);
            finish_sweep(fn_tab);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
